// File: rtl/memory_bus_responder.sv
// Single-port word memory answering CPU bus cycles with a registered, active-low
// ready strobe after a fixed number of wait states.
module memory_bus_responder #(
  parameter int    ADDR_BITS   = 16,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] address_in,
  input  logic [3:0]  bus_status,
  input  logic [15:0] wr_data,
  input  logic [1:0]  byte_enable,
  output logic [15:0] data_out,
  output logic        readyb
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  localparam int         WORDS    = 1 << (ADDR_BITS - 1);
  localparam logic [3:0] CNT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [3:0] BS_FETCH = 4'b1001;
  localparam logic [3:0] BS_READ  = 4'b1010;
  localparam logic [3:0] BS_WRITE = 4'b1011;

  logic [15:0] mem [WORDS];

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:1] addr_q, addr_d;
  logic [3:0]           status_q, status_d;
  logic [15:0]          wdata_q, wdata_d;
  logic [1:0]           be_q, be_d;
  logic [15:0]          data_q, data_d;
  logic                 readyb_q, readyb_d;
  logic                 req_valid;
  logic                 cur_write;
  logic                 mem_we;
  logic                 unused_addr;

  // Byte address bit 0 and the bits above the decoded range only alias.
  assign unused_addr = ^address_in;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed by the combinational processes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      status_q <= 4'd0;
      wdata_q  <= 16'h0000;
      be_q     <= 2'b00;
      data_q   <= 16'h0000;
      readyb_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      status_q <= status_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      data_q   <= data_d;
      readyb_q <= readyb_d;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    req_valid = bus_status inside {BS_FETCH, BS_READ, BS_WRITE};
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    status_d  = status_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = address_in[ADDR_BITS-1:1];
          status_d = bus_status;
          wdata_d  = wr_data;
          be_d     = byte_enable;
          if (WAIT_STATES == 0) begin
            state_d = ST_RESPOND;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESPOND;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // The *_d request fields hold live inputs on a zero-wait accept and the
  // latched request otherwise, so both paths into RESPOND use them.
  always_comb begin
    cur_write = (status_d == BS_WRITE);
    mem_we    = (state_d == ST_RESPOND) && cur_write;
    readyb_d  = (state_d != ST_RESPOND);
    data_d    = data_q;
    if ((state_d == ST_RESPOND) && !cur_write) data_d = mem[addr_d];
  end

  // NOTE: the memory array has no reset; reset only blocks a pending write.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      if (be_d[0]) mem[addr_d][7:0]  <= wdata_d[7:0];
      if (be_d[1]) mem[addr_d][15:8] <= wdata_d[15:8];
    end
  end

  assign data_out = data_q;
  assign readyb   = readyb_q;

endmodule

// File: tb/tb_memory_bus_responder.sv
// Directed bench: four responders with WAIT_STATES 0..3 exercised through
// read, write, alias, idle-code, abort and back-to-back fetch scenarios.
module tb_memory_bus_responder;

  localparam logic [3:0] BS_IDLE  = 4'b1111;
  localparam logic [3:0] BS_FETCH = 4'b1001;
  localparam logic [3:0] BS_READ  = 4'b1010;
  localparam logic [3:0] BS_WRITE = 4'b1011;

  logic        clk = 1'b0;
  logic        reset       [4];
  logic [19:0] address_in  [4];
  logic [3:0]  bus_status  [4];
  logic [15:0] wr_data     [4];
  logic [1:0]  byte_enable [4];
  logic [15:0] data_out    [4];
  logic        readyb      [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    memory_bus_responder #(
      .ADDR_BITS  (16),
      .WAIT_STATES(g),
      .INIT_FILE  ("")
    ) u_dut (
      .clk        (clk),
      .reset      (reset[g]),
      .address_in (address_in[g]),
      .bus_status (bus_status[g]),
      .wr_data    (wr_data[g]),
      .byte_enable(byte_enable[g]),
      .data_out   (data_out[g]),
      .readyb     (readyb[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transfer on instance k; lat counts negedges after the accept edge
  // before readyb is seen low (equals WAIT_STATES), -1 on timeout.
  task automatic xfer(input int k, input logic [3:0] st, input logic [19:0] a,
                      input logic [15:0] wd, input logic [1:0] be,
                      output logic [15:0] rd, output int lat);
    @(negedge clk);
    bus_status[k]  = st;
    address_in[k]  = a;
    wr_data[k]     = wd;
    byte_enable[k] = be;
    @(posedge clk);
    #1;
    bus_status[k]  = BS_IDLE;
    address_in[k]  = a ^ 20'h00006;
    wr_data[k]     = ~wd;
    byte_enable[k] = 2'b11;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (readyb[k] == 1'b0) begin
        lat = i;
        break;
      end
    end
    rd = data_out[k];
    @(negedge clk);
    check($sformatf("pulse_width_i%0d", k), 32'(readyb[k]), 32'd1);
  endtask

  task automatic do_write(input int k, input logic [19:0] a, input logic [15:0] wd,
                          input logic [1:0] be, input string tag);
    logic [15:0] rd;
    int          lat;
    xfer(k, BS_WRITE, a, wd, be, rd, lat);
    check({tag, "_lat"}, 32'(lat), 32'(k));
  endtask

  task automatic do_read(input int k, input logic [3:0] st, input logic [19:0] a,
                         input logic [15:0] exp, input string tag);
    logic [15:0] rd;
    int          lat;
    xfer(k, st, a, 16'h0000, 2'b00, rd, lat);
    check({tag, "_lat"}, 32'(lat), 32'(k));
    check({tag, "_data"}, 32'(rd), 32'(exp));
  endtask

  task automatic count_lows(input int k, input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (readyb[k] == 1'b0) lows++;
    end
  endtask

  initial begin
    int          lows;
    int          pulse_cyc [3];
    logic [15:0] pulse_dat [3];
    int          npulse;
    logic [19:0] addr;

    for (int k = 0; k < 4; k++) begin
      reset[k]       = 1'b1;
      bus_status[k]  = BS_IDLE;
      address_in[k]  = 20'h0;
      wr_data[k]     = 16'h0;
      byte_enable[k] = 2'b00;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_readyb_i%0d", k), 32'(readyb[k]), 32'd1);
      check($sformatf("rst_data_i%0d", k), 32'(data_out[k]), 32'h0000);
      reset[k] = 1'b0;
    end

    // WAIT_STATES=1: code fetch from the top of the aliased space after reset.
    do_write(1, 20'h0FFF0, 16'hEA90, 2'b11, "w1_ea90");
    @(negedge clk);
    reset[1] = 1'b1;
    @(negedge clk);
    reset[1] = 1'b0;
    check("w1_rst_data", 32'(data_out[1]), 32'h0000);
    do_read(1, BS_FETCH, 20'hFFFF0, 16'hEA90, "w1_fetch");

    // WAIT_STATES=0: byte-lane write, lane-less write, aliasing, idle codes.
    do_write(0, 20'h00010, 16'h1234, 2'b11, "w0_full");
    do_write(0, 20'h00010, 16'hBEEF, 2'b01, "w0_low");
    do_read(0, BS_READ, 20'h00011, 16'h12EF, "w0_rd_odd");
    do_write(0, 20'h00010, 16'h5555, 2'b00, "w0_be00");
    check("w0_hold_after_wr", 32'(data_out[0]), 32'h12EF);
    do_read(0, BS_READ, 20'h00010, 16'h12EF, "w0_rd_be00");
    @(negedge clk);
    bus_status[0] = 4'b0000;
    address_in[0] = 20'h00010;
    count_lows(0, 10, lows);
    bus_status[0] = 4'b1100;
    count_lows(0, 10, lows);
    bus_status[0] = BS_IDLE;
    check("w0_idle_codes", 32'(lows), 32'd0);
    check("w0_idle_hold", 32'(data_out[0]), 32'h12EF);
    do_read(0, BS_READ, 20'h10010, 16'h12EF, "w0_alias");
    @(negedge clk);
    reset[0]       = 1'b1;
    bus_status[0]  = BS_WRITE;
    address_in[0]  = 20'h00010;
    wr_data[0]     = 16'h0000;
    byte_enable[0] = 2'b11;
    @(negedge clk);
    reset[0]      = 1'b0;
    bus_status[0] = BS_IDLE;
    count_lows(0, 3, lows);
    check("w0_rst_prio_ready", 32'(lows), 32'd0);
    do_read(0, BS_READ, 20'h00010, 16'h12EF, "w0_rst_prio_mem");

    // WAIT_STATES=2: reset aborts a write while it waits.
    do_write(2, 20'h00020, 16'hA5A5, 2'b11, "w2_init");
    do_read(2, BS_READ, 20'h00020, 16'hA5A5, "w2_rd");
    @(negedge clk);
    bus_status[2]  = BS_WRITE;
    address_in[2]  = 20'h00020;
    wr_data[2]     = 16'h0000;
    byte_enable[2] = 2'b11;
    @(posedge clk);
    #1;
    bus_status[2] = BS_IDLE;
    @(negedge clk);
    reset[2] = 1'b1;
    @(negedge clk);
    reset[2] = 1'b0;
    count_lows(2, 4, lows);
    check("w2_abort_ready", 32'(lows), 32'd0);
    check("w2_abort_data", 32'(data_out[2]), 32'h0000);
    do_read(2, BS_READ, 20'h00020, 16'hA5A5, "w2_abort_mem");

    // WAIT_STATES=3: fetch held active, address stepped on each pulse.
    do_write(3, 20'h00100, 16'h1111, 2'b11, "w3_a");
    do_write(3, 20'h00102, 16'h2222, 2'b11, "w3_b");
    do_write(3, 20'h00104, 16'h3333, 2'b11, "w3_c");
    @(negedge clk);
    addr          = 20'h00100;
    bus_status[3] = BS_FETCH;
    address_in[3] = addr;
    npulse        = 0;
    for (int cyc = 0; cyc < 40 && npulse < 3; cyc++) begin
      @(negedge clk);
      if (readyb[3] == 1'b0) begin
        pulse_cyc[npulse] = cyc;
        pulse_dat[npulse] = data_out[3];
        npulse++;
        addr          = addr + 20'd2;
        address_in[3] = addr;
        if (npulse == 3) bus_status[3] = BS_IDLE;
      end
    end
    check("w3_npulse", 32'(npulse), 32'd3);
    if (npulse == 3) begin
      check("w3_first", 32'(pulse_cyc[0]), 32'd3);
      check("w3_period1", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd5);
      check("w3_period2", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd5);
      check("w3_data0", 32'(pulse_dat[0]), 32'h1111);
      check("w3_data1", 32'(pulse_dat[1]), 32'h2222);
      check("w3_data2", 32'(pulse_dat[2]), 32'h3333);
    end
    count_lows(3, 8, lows);
    check("w3_stream_stop", 32'(lows), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
